// File: rtl/rate_div_pkg.sv
// Shared types and defaults for the multi-rate divider.
// Optional feature macro: RATE_DIV_SHADOW_PERIOD_EN.
package rate_div_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int WIDTH_DEF    = 8;
    localparam int CHANNELS_DEF = 2;

endpackage

// File: rtl/rate_div_channel.sv
// One divider channel: counter, effective period, registered out/tick.
// RATE_DIV_SHADOW_PERIOD_EN latches the period only at wrap and clear.
module rate_div_channel
    import rate_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    output logic             out,
    output logic             tick
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_out;
    logic             r_tick;
    logic [WIDTH-1:0] w_pe;
    logic             w_wrap;
    logic             w_sq;
    mode_e            w_mode;

    assign w_mode = mode_e'(mode);

`ifdef RATE_DIV_SHADOW_PERIOD_EN
    logic [WIDTH-1:0] r_pe;

    // Frequency changes only land on a cycle boundary, so no runt cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pe <= '1;
        end else if (clear || (enable && w_wrap)) begin
            r_pe <= period;
        end
    end

    assign w_pe = r_pe;
`else
    assign w_pe = period;
`endif

    assign w_wrap = (r_cnt >= w_pe);
    assign w_sq   = (r_cnt > (w_pe >> 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_out  <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_out  <= 1'b0;
        end else if (enable) begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_tick <= w_wrap;
            r_out  <= (w_mode == MODE_PULSE) ? w_wrap : w_sq;
        end else begin
            r_tick <= 1'b0;
            r_out  <= (w_mode == MODE_PULSE) ? 1'b0 : r_out;
        end
    end

    assign out  = r_out;
    assign tick = r_tick;

endmodule

// File: rtl/multi_rate_divider.sv
// Bank of independent clock-enable dividers sharing clear and reset.
// Honours RATE_DIV_SHADOW_PERIOD_EN (see rate_div_channel).
module multi_rate_divider
    import rate_div_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int CHANNELS = CHANNELS_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*WIDTH-1:0] period,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       tick
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        rate_div_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .enable(enable[g]),
            .mode  (mode[g]),
            .period(period[g*WIDTH +: WIDTH]),
            .out   (out[g]),
            .tick  (tick[g])
        );
    end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed bench for multi_rate_divider (3 channels, 8-bit).
// Expectations follow RATE_DIV_SHADOW_PERIOD_EN when it is defined.
module tb_multi_rate_divider;

    localparam int W  = 8;
    localparam int CH = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic [CH-1:0]   enable;
    logic [CH-1:0]   mode;
    logic [CH*W-1:0] period;
    logic [CH-1:0]   out;
    logic [CH-1:0]   tick;

    int n_vec = 0;
    int n_err = 0;

    multi_rate_divider #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .enable(enable),
        .mode  (mode),
        .period(period),
        .out   (out),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       en;
        logic       md;
        logic [7:0] p;
        logic       eo;
        logic       et;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p(input int c, input int p);
        period[c*W +: W] = p[W-1:0];
    endtask

    task automatic do_clear();
        clear = 1'b1;
        edge1();
        clear = 1'b0;
    endtask

    vec_t tbl[15];
    int   cnt_t;
    int   first;

    initial begin
        reset  = 1'b1;
        clear  = 1'b0;
        enable = '0;
        mode   = '0;
        period = '0;
        #3;
        chk("reset_out", 32'(out), 0);
        chk("reset_tick", 32'(tick), 0);
        #4;
        reset = 1'b0;
        edge1();

        // Channel 0 table, P=2: cycle of 3, square high on the wrap cycle.
        tbl[0]  = '{1, 1, 0, 2, 0, 0};
        tbl[1]  = '{0, 1, 0, 2, 0, 0};
        tbl[2]  = '{0, 1, 0, 2, 0, 0};
        tbl[3]  = '{0, 1, 0, 2, 1, 1};
        tbl[4]  = '{0, 1, 0, 2, 0, 0};
        tbl[5]  = '{0, 0, 0, 2, 0, 0};
        tbl[6]  = '{0, 0, 1, 2, 0, 0};
        tbl[7]  = '{0, 1, 1, 2, 0, 0};
        tbl[8]  = '{0, 1, 1, 2, 1, 1};
        tbl[9]  = '{0, 1, 0, 2, 0, 0};
        tbl[10] = '{0, 1, 0, 2, 0, 0};
        tbl[11] = '{0, 1, 0, 2, 1, 1};
        tbl[12] = '{0, 0, 0, 2, 1, 0};
        tbl[13] = '{0, 1, 0, 2, 0, 0};
        tbl[14] = '{1, 1, 0, 2, 0, 0};
        for (int i = 0; i < 15; i++) begin
            clear     = tbl[i].clr;
            enable[0] = tbl[i].en;
            mode[0]   = tbl[i].md;
            set_p(0, int'(tbl[i].p));
            edge1();
            chk($sformatf("tbl%0d_out", i), 32'(out[0]), 32'(tbl[i].eo));
            chk($sformatf("tbl%0d_tick", i), 32'(tick[0]), 32'(tbl[i].et));
        end
        clear  = 1'b0;
        enable = '0;

        // Legacy: P=255 square, 128 low / 128 high, one tick per 256.
        mode[0] = 1'b0;
        set_p(0, 255);
        do_clear();
        enable[0] = 1'b1;
        for (int k = 1; k <= 512; k++) begin
            edge1();
            chk("legacy_out", 32'(out[0]),
                32'((((k - 1) % 256) > 127) ? 1 : 0));
            chk("legacy_tick", 32'(tick[0]),
                32'((((k - 1) % 256) == 255) ? 1 : 0));
        end
        enable = '0;

        // Pulse P=4: tick at edge 5, then 1 en, 3 off, 4 en -> edge 13.
        mode[0] = 1'b1;
        set_p(0, 4);
        do_clear();
        for (int k = 1; k <= 13; k++) begin
            enable[0] = !(k >= 7 && k <= 9);
            edge1();
            chk("pulse_tick", 32'(tick[0]),
                32'((k == 5 || k == 13) ? 1 : 0));
            chk("pulse_out", 32'(out[0]), 32'(tick[0] ? 1 : 0));
        end
        enable = '0;

        // P=0: tick every enabled cycle, square out stuck low.
        mode[0] = 1'b0;
        set_p(0, 0);
        do_clear();
        enable[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            edge1();
            chk("p0_tick", 32'(tick[0]), 1);
            chk("p0_out", 32'(out[0]), 0);
        end
        enable = '0;

        // P=1 square alternates 0,1.
        set_p(0, 1);
        do_clear();
        enable[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            edge1();
            chk("p1_out", 32'(out[0]), 32'(k % 2));
        end
        enable = '0;

        // Period change 9 -> 3 at cnt=6.
        set_p(0, 9);
        do_clear();
        enable[0] = 1'b1;
        for (int k = 0; k < 6; k++) edge1();
        set_p(0, 3);
        for (int k = 1; k <= 12; k++) begin
            edge1();
`ifdef RATE_DIV_SHADOW_PERIOD_EN
            chk("pchg_tick", 32'(tick[0]), 32'((k % 4) == 0 ? 1 : 0));
`else
            chk("pchg_tick", 32'(tick[0]), 32'((k % 4) == 1 ? 1 : 0));
`endif
        end
        enable = '0;

        // Clear mid-count with out high, then restart from 0.
        set_p(0, 9);
        do_clear();
        enable[0] = 1'b1;
        for (int k = 0; k < 6; k++) edge1();
        chk("preclr_out", 32'(out[0]), 1);
        do_clear();
        chk("clr_out", 32'(out), 0);
        chk("clr_tick", 32'(tick), 0);
        for (int k = 1; k <= 10; k++) begin
            edge1();
            chk("postclr_tick", 32'(tick[0]), 32'(k == 10 ? 1 : 0));
        end
        enable = '0;

        // Async reset between edges, then resume from 0.
        set_p(0, 0);
        do_clear();
        enable[0] = 1'b1;
        edge1();
        chk("prerst_tick", 32'(tick[0]), 1);
        reset = 1'b1;
        #1;
        chk("async_tick", 32'(tick), 0);
        chk("async_out", 32'(out), 0);
        set_p(0, 3);
        #1;
        reset = 1'b0;
        first = -1;
        for (int k = 1; k <= 300 && first < 0; k++) begin
            edge1();
            if (tick[0]) first = k;
        end
`ifdef RATE_DIV_SHADOW_PERIOD_EN
        chk("rst_resume", 32'(first), 256);
`else
        chk("rst_resume", 32'(first), 4);
`endif
        enable = '0;

        // Independence: P=2/5/7, modes sq/pulse/sq; ch0 drops out later.
        mode = 3'b010;
        set_p(0, 2);
        set_p(1, 5);
        set_p(2, 7);
        do_clear();
        enable = 3'b111;
        for (int k = 1; k <= 48; k++) begin
            if (k == 25) enable[0] = 1'b0;
            edge1();
            if (k <= 24)
                chk("ind_t0", 32'(tick[0]), 32'((k % 3) == 0 ? 1 : 0));
            else
                chk("ind_t0_off", 32'(tick[0]), 0);
            chk("ind_t1", 32'(tick[1]), 32'((k % 6) == 0 ? 1 : 0));
            chk("ind_o1", 32'(out[1]), 32'((k % 6) == 0 ? 1 : 0));
            chk("ind_t2", 32'(tick[2]), 32'((k % 8) == 0 ? 1 : 0));
        end
        enable = '0;

        cnt_t = n_vec;
        $display("== %0d vectors applied, %0d miscompares ==", cnt_t, n_err);
        $finish;
    end

endmodule
